// File: rtl/mux_seq_pkg.sv
// Shared constants and types for the four-channel sequential multiplexer.
package mux_seq_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] ch_idx_t;

    localparam ch_idx_t PTR_RST = '0;
    localparam ch_idx_t SEL_RST = '0;

endpackage

// File: rtl/rr_arbiter_4.sv
// Combinational four-way round-robin arbiter; search starts at ptr and wraps.
module rr_arbiter_4
    import mux_seq_pkg::*;
(
    input  logic [NCH-1:0] full,
    input  ch_idx_t        ptr,
    output logic           grant_valid,
    output ch_idx_t        grant_idx
);

    ch_idx_t cand;

    // Walk from lowest to highest priority so the nearest request to ptr wins last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = ptr;
        cand        = ptr;
        for (int k = NCH - 1; k >= 0; k--) begin
            cand = ch_idx_t'(ptr + ch_idx_t'(k));
            if (full[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_sequencial.sv
// Four-channel time-division multiplexer with per-channel one-entry holding registers.
// Optional registered even-parity output P is enabled by defining MUX_SEQ_PARITY_EN.
module mux_sequencial
    import mux_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NCH*WIDTH-1:0] D,
    input  logic [NCH-1:0]       V,
    output logic [NCH-1:0]       R,
    output logic [WIDTH-1:0]     Y,
    output logic [SEL_W-1:0]     S,
    output logic                 YV,
    input  logic                 YR
`ifdef MUX_SEQ_PARITY_EN
    ,
    output logic                 P
`endif
);

    logic [NCH-1:0]   full;
    logic [WIDTH-1:0] hold [NCH];
    ch_idx_t          ptr;
    logic             grant_valid;
    ch_idx_t          grant_idx;
    logic             slot_free;
    logic             load;

    assign R         = ~full;
    assign slot_free = ~YV | YR;
    assign load      = slot_free & grant_valid;

    rr_arbiter_4 u_arb (
        .full        (full),
        .ptr         (ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // A granted channel is always full, so capture and clear never hit the same bit.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            full <= '0;
            ptr  <= PTR_RST;
            Y    <= '0;
            S    <= SEL_RST;
            YV   <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (V[i] && !full[i]) begin
                    full[i] <= 1'b1;
                    hold[i] <= D[i*WIDTH +: WIDTH];
                end else if (load && (grant_idx == ch_idx_t'(i))) begin
                    full[i] <= 1'b0;
                end
            end
            if (slot_free) begin
                if (grant_valid) begin
                    Y   <= hold[grant_idx];
                    S   <= grant_idx;
                    YV  <= 1'b1;
                    ptr <= ch_idx_t'(grant_idx + 2'd1);
                end else begin
                    YV  <= 1'b0;
                end
            end
        end
    end

`ifdef MUX_SEQ_PARITY_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            P <= 1'b0;
        end else if (load) begin
            P <= ^hold[grant_idx];
        end
    end
`endif

endmodule

// File: tb/tb_mux_sequencial.sv
// Scoreboard bench for mux_sequencial: stimulus pushes expected words, a monitor pops on each accepted output.
module tb_mux_sequencial;

    logic        CLK;
    logic        RST_N;
    logic [15:0] D;
    logic [3:0]  V;
    logic [3:0]  R;
    logic [3:0]  Y;
    logic [1:0]  S;
    logic        YV;
    logic        YR;
`ifdef MUX_SEQ_PARITY_EN
    logic        P;
`endif

    mux_sequencial #(.WIDTH(4)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .D     (D),
        .V     (V),
        .R     (R),
        .Y     (Y),
        .S     (S),
        .YV    (YV),
        .YR    (YR)
`ifdef MUX_SEQ_PARITY_EN
        ,
        .P     (P)
`endif
    );

    typedef struct {
        logic [1:0] s;
        logic [3:0] y;
        logic       p;
    } exp_t;

    exp_t sc_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic push(input logic [1:0] s, input logic [3:0] y, input logic p);
        exp_t e;
        e.s = s;
        e.y = y;
        e.p = p;
        sc_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sc_q.size() != 0 && n < budget) begin
            @(posedge CLK);
            n++;
        end
        #1;
        check("drain_queue_empty", sc_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        V     = '0;
        #2;
        RST_N = 1'b1;
    endtask

    // Monitor: a word is consumed at the edge following a cycle with YV & YR.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST_N && YV && YR) begin
                if (sc_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: got S=%0d Y=%0h with nothing expected at %0t", S, Y, $time);
                end else begin
                    e = sc_q.pop_front();
                    check("out_s", S, e.s);
                    check("out_y", Y, e.y);
`ifdef MUX_SEQ_PARITY_EN
                    check("out_p", P, e.p);
`endif
                end
            end
        end
    end

    initial begin
        logic [3:0] rr_par;
        RST_N = 1'b0;
        V     = '0;
        D     = '0;
        YR    = 1'b1;

        // Reset and idle
        #2;
        check("rst_r", R, 4'hF);
        check("rst_yv", YV, 0);
        check("rst_y", Y, 0);
        check("rst_s", S, 0);
`ifdef MUX_SEQ_PARITY_EN
        check("rst_p", P, 0);
`endif
        #10;
        RST_N = 1'b1;
        repeat (10) begin
            @(posedge CLK);
            #1;
            check("idle_yv", YV, 0);
            check("idle_r", R, 4'hF);
        end

        // Single channel 2 word
        D = 16'h0A00;
        V = 4'b0100;
        push(2'd2, 4'hA, 1'b0);
        @(posedge CLK);
        #1;
        V = '0;
        check("single_r_low", R, 4'b1011);
        check("single_yv_pre", YV, 0);
        @(posedge CLK);
        #1;
        check("single_yv", YV, 1);
        check("single_y", Y, 4'hA);
        check("single_s", S, 2);
        check("single_r_back", R, 4'hF);
        @(posedge CLK);
        #1;
        check("single_yv_drop", YV, 0);
        wait_drain(10);

        // Round-robin with all channels continuously valid
        do_reset();
        YR     = 1'b1;
        D      = 16'h4321;
        V      = 4'hF;
        rr_par = 4'b1011;
        for (int k = 0; k < 10; k++) begin
            push(2'(k % 4), 4'(k % 4 + 1), rr_par[k % 4]);
        end
        repeat (8) @(posedge CLK);
        #1;
        V = '0;
        wait_drain(20);

        // Backpressure with all four holding registers full
        do_reset();
        YR = 1'b0;
        D  = 16'h8765;
        V  = 4'hF;
        push(2'd0, 4'h5, 1'b0);
        push(2'd1, 4'h6, 1'b0);
        push(2'd2, 4'h7, 1'b1);
        push(2'd3, 4'h8, 1'b1);
        push(2'd0, 4'h5, 1'b0);
        repeat (3) @(posedge CLK);
        #1;
        V = '0;
        repeat (5) begin
            check("stall_r", R, 4'b0000);
            check("stall_yv", YV, 1);
            check("stall_y", Y, 4'h5);
            check("stall_s", S, 0);
            @(posedge CLK);
            #1;
        end
        YR = 1'b1;
        wait_drain(20);

        // Asynchronous reset while a word is stalled and full = 1011
        do_reset();
        YR = 1'b0;
        D  = 16'h9032;
        V  = 4'b1011;
        repeat (3) @(posedge CLK);
        #1;
        V = '0;
        check("mid_pre_yv", YV, 1);
        check("mid_pre_r", R, 4'b0100);
        #2;
        RST_N = 1'b0;
        #1;
        check("mid_rst_yv", YV, 0);
        check("mid_rst_r", R, 4'hF);
        check("mid_rst_y", Y, 0);
        check("mid_rst_s", S, 0);
        #2;
        RST_N = 1'b1;
        YR    = 1'b1;
        repeat (6) begin
            @(posedge CLK);
            #1;
            check("mid_post_yv", YV, 0);
        end

        // Parity vectors on channel 0: 0111 then 0110
        do_reset();
        YR = 1'b1;
        D  = 16'h0007;
        V  = 4'b0001;
        push(2'd0, 4'h7, 1'b1);
        push(2'd0, 4'h6, 1'b0);
        @(posedge CLK);
        #1;
        D = 16'h0006;
        repeat (2) @(posedge CLK);
        #1;
        V = '0;
        wait_drain(10);

        repeat (3) @(posedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
